stage_1: RTL and testbench

//  Front stage of the 2-stage, 4-way, 16-set, 32 B-line read-only cache. Each cycle it

---
 rtl/stage_1_pkg.sv | 37 +++
 rtl/stage_1_if.sv | 32 +++
 rtl/stage_1_plru_victim.sv | 13 +
 rtl/stage_1.sv | 123 ++++++++++++
 tb/tb_stage_1.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/stage_1_pkg.sv
// Shared types and widths for the two-stage read-only cache front end.
package stage_1_pkg;

   localparam int unsigned WAYS   = 4;
   localparam int unsigned SETS   = 16;
   localparam int unsigned LINE_W = 256;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned MASK_W = 4;
   localparam int unsigned TAG_W  = 24;
   localparam int unsigned SET_W  = $clog2(SETS);
   localparam int unsigned OFF_W  = 5;
   localparam int unsigned LRU_W  = WAYS - 1;
   localparam int unsigned WAY_W  = $clog2(WAYS);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [TAG_W-1:0]  tag;
      logic [SET_W-1:0]  set;
      logic [OFF_W-1:0]  offset;
      logic [MASK_W-1:0] rmask;
   } stage_reg_t;

   typedef enum logic [1:0] {LOOKUP, MISS, REPLAY, WAIT} state_t;

   // Split a byte address into the fields stage_2 compares against
   function automatic stage_reg_t decode_req(input logic [ADDR_W-1:0] addr,
                                             input logic [MASK_W-1:0] rmask);
      stage_reg_t r;
      r.addr   = addr;
      r.tag    = TAG_W'(addr[ADDR_W-1:OFF_W+SET_W]);
      r.set    = addr[OFF_W+SET_W-1:OFF_W];
      r.offset = addr[OFF_W-1:0];
      r.rmask  = rmask;
      return r;
   endfunction

endpackage

// File: rtl/stage_1_if.sv
// Request, refill and SRAM-port bundle between stage_1 and its neighbours.
interface stage_1_if;
   import stage_1_pkg::*;

   logic [ADDR_W-1:0] ufp_addr;
   logic [MASK_W-1:0] ufp_rmask;
   logic              halt;
   logic [LRU_W-1:0]  lru_read;
   logic [LINE_W-1:0] dfp_rdata;
   logic              dfp_resp;
   stage_reg_t        stage_reg;
   logic              dfp_resp_reg;
   logic              arr_csb;
   logic [SET_W-1:0]  arr_addr;
   logic [WAYS-1:0]   arr_web;
   logic [LINE_W-1:0] data_din;
   logic [TAG_W-1:0]  tag_din;
   logic              valid_din;

   modport slave (
      input  ufp_addr, ufp_rmask, halt, lru_read, dfp_rdata, dfp_resp,
      output stage_reg, dfp_resp_reg, arr_csb, arr_addr, arr_web,
             data_din, tag_din, valid_din
   );

   modport master (
      output ufp_addr, ufp_rmask, halt, lru_read, dfp_rdata, dfp_resp,
      input  stage_reg, dfp_resp_reg, arr_csb, arr_addr, arr_web,
             data_din, tag_din, valid_din
   );

endinterface

// File: rtl/stage_1_plru_victim.sv
// Tree-PLRU victim select: bit 0 picks the half, bits 1/2 pick the way within it.
module plru_victim
   import stage_1_pkg::*;
(
   input  logic [LRU_W-1:0] lru,
   output logic [WAY_W-1:0] way_c
);

   always_comb begin
      way_c = lru[0] ? {1'b1, lru[2]} : {1'b0, lru[1]};
   end

endmodule

// File: rtl/stage_1.sv
// Cache front stage: request capture, SRAM read issue, and refill/replay on stage_2 miss.
module stage_1
   import stage_1_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   stage_1_if.slave bus
);

   state_t            state_q, state_d;
   stage_reg_t        stage_q, stage_d;
   logic              resp_q, resp_d;
   logic              capture;
   logic [WAY_W-1:0]  victim;

   logic              csb_c;
   logic [SET_W-1:0]  addr_c;
   logic [WAYS-1:0]   web_c;
   logic [LINE_W-1:0] data_c;
   logic [TAG_W-1:0]  tag_c;
   logic              valid_c;

   plru_victim u_plru (
      .lru   (bus.lru_read),
      .way_c (victim)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= LOOKUP;
         stage_q <= '0;
         resp_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         resp_q  <= resp_d;
      end
   end

   // SRAM controls are combinational so the read/write lands on the same edge as the capture
   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      resp_d  = resp_q;
      capture = 1'b0;
      csb_c   = 1'b1;
      addr_c  = '0;
      web_c   = '1;
      data_c  = '0;
      tag_c   = '0;
      valid_c = 1'b0;

      unique case (state_q)
         LOOKUP: begin
            if (bus.halt) state_d = MISS;
            else          capture = 1'b1;
         end
         MISS: begin
            if (bus.dfp_resp) begin
               csb_c         = 1'b0;
               addr_c        = stage_q.set;
               web_c[victim] = 1'b0;
               data_c        = bus.dfp_rdata;
               tag_c         = stage_q.tag;
               valid_c       = 1'b1;
               resp_d        = 1'b1;
               state_d       = REPLAY;
            end
         end
         REPLAY: begin
            csb_c   = 1'b0;
            addr_c  = stage_q.set;
            state_d = WAIT;
         end
         WAIT: begin
            if (!bus.halt) begin
               resp_d  = 1'b0;
               state_d = LOOKUP;
               capture = 1'b1;
            end
         end
      endcase

      if (capture) begin
         stage_d = decode_req(bus.ufp_addr, bus.ufp_rmask);
         if (bus.ufp_rmask != '0) begin
            csb_c  = 1'b0;
            addr_c = bus.ufp_addr[OFF_W+SET_W-1:OFF_W];
         end
      end

      if (rst) begin
         csb_c   = 1'b1;
         addr_c  = '0;
         web_c   = '1;
         data_c  = '0;
         tag_c   = '0;
         valid_c = 1'b0;
      end
   end

   assign bus.stage_reg    = stage_q;
   assign bus.dfp_resp_reg = resp_q;
   assign bus.arr_csb      = csb_c;
   assign bus.arr_addr     = addr_c;
   assign bus.arr_web      = web_c;
   assign bus.data_din     = data_c;
   assign bus.tag_din      = tag_c;
   assign bus.valid_din    = valid_c;

   a_resp_in_miss: assert property (@(posedge clk) disable iff (rst)
      bus.dfp_resp |-> state_q == MISS)
      else $error("stage_1: dfp_resp outside MISS");

   a_no_halt_in_wait: assert property (@(posedge clk) disable iff (rst)
      state_q == WAIT |-> !bus.halt)
      else $error("stage_1: halt still high after replay");

   a_one_way_written: assert property (@(posedge clk) disable iff (rst)
      $onehot0(~bus.arr_web))
      else $error("stage_1: more than one way written");

endmodule

// File: tb/tb_stage_1.sv
// Scoreboard bench for stage_1 with a behavioural 4-way SRAM model.
module tb_stage_1;
   import stage_1_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   stage_1_if bus();

   stage_1 dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int total = 0;
   int bad   = 0;

   stage_reg_t exp_q[$];
   stage_reg_t exp_s, held;

   localparam logic [255:0] LINE_A = {8{32'hCAFE_0001}};
   localparam logic [255:0] LINE_B = {8{32'hBEEF_0002}};
   localparam logic [255:0] LINE_C = {8{32'h1234_5678}};

   // SRAM model: 1-cycle read latency, write on active-low per-way enable
   logic [255:0] mem_data  [4][16];
   logic [23:0]  mem_tag   [4][16];
   logic         mem_valid [4][16];
   logic [255:0] rd_data   [4];
   logic [23:0]  rd_tag    [4];
   logic         rd_valid  [4];

   always @(posedge clk) begin
      if (!bus.arr_csb) begin
         for (int w = 0; w < 4; w++) begin
            if (!bus.arr_web[w]) begin
               mem_data[w][bus.arr_addr]  <= bus.data_din;
               mem_tag[w][bus.arr_addr]   <= bus.tag_din;
               mem_valid[w][bus.arr_addr] <= bus.valid_din;
            end
            rd_data[w]  <= mem_data[w][bus.arr_addr];
            rd_tag[w]   <= mem_tag[w][bus.arr_addr];
            rd_valid[w] <= mem_valid[w][bus.arr_addr];
         end
      end
   end

   function automatic stage_reg_t model(input logic [31:0] a, input logic [3:0] m);
      stage_reg_t s;
      s.addr   = a;
      s.tag    = 24'(a >> 9);
      s.set    = 4'((a >> 5) & 32'hF);
      s.offset = 5'(a & 32'h1F);
      s.rmask  = m;
      return s;
   endfunction

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic [31:0] a, input logic [3:0] m);
      bus.ufp_addr  = a;
      bus.ufp_rmask = m;
   endtask

   task automatic test_reset;
      @(negedge clk);
      total++; if (bus.stage_reg !== '0) begin bad++; $display("FAIL reset_stage got=%h want=0", bus.stage_reg); end
      total++; if (bus.arr_csb !== 1'b1 || bus.arr_web !== 4'hF) begin bad++; $display("FAIL reset_arr got csb=%b web=%b want 1/1111", bus.arr_csb, bus.arr_web); end
      rst = 1'b0;
      drive(32'h0000_05A0, 4'hF);
      exp_s = model(32'h0000_05A0, 4'hF);
      tick;
      total++; if (bus.stage_reg !== exp_s) begin bad++; $display("FAIL pre_reset_capture got=%h want=%h", bus.stage_reg, exp_s); end
      #2 rst = 1'b1;
      #1;
      total++; if (bus.stage_reg !== '0 || bus.stage_reg.rmask !== 4'h0) begin bad++; $display("FAIL midcycle_stage got=%h want=0", bus.stage_reg); end
      total++; if (bus.dfp_resp_reg !== 1'b0) begin bad++; $display("FAIL midcycle_resp got=%b want=0", bus.dfp_resp_reg); end
      total++; if (bus.arr_csb !== 1'b1 || bus.arr_web !== 4'hF || bus.arr_addr !== 4'h0) begin bad++; $display("FAIL midcycle_arr got csb=%b web=%b addr=%h want 1/1111/0", bus.arr_csb, bus.arr_web, bus.arr_addr); end
      total++; if (bus.data_din !== '0 || bus.tag_din !== '0 || bus.valid_din !== 1'b0) begin bad++; $display("FAIL midcycle_din got tag=%h valid=%b want 0/0", bus.tag_din, bus.valid_din); end
      @(negedge clk);
      rst = 1'b0;
      drive(32'h0, 4'h0);
   endtask

   task automatic test_pipelined_hits;
      logic [31:0] a;
      logic [3:0]  m;
      bus.halt = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a = (i < 3) ? 32'h100 + 32'(4 * i) : 32'h10C;
         m = (i < 3) ? 4'hF : 4'h0;
         drive(a, m);
         exp_q.push_back(model(a, m));
         #1;
         if (m != 4'h0) begin
            total++; if (bus.arr_csb !== 1'b0 || bus.arr_addr !== 4'd8 || bus.arr_web !== 4'hF) begin bad++; $display("FAIL hit_read[%0d] got csb=%b addr=%0d web=%b want 0/8/1111", i, bus.arr_csb, bus.arr_addr, bus.arr_web); end
         end else begin
            total++; if (bus.arr_csb !== 1'b1) begin bad++; $display("FAIL bubble_read got csb=%b want 1", bus.arr_csb); end
         end
         @(negedge clk);
         exp_s = exp_q.pop_front();
         total++; if (bus.stage_reg !== exp_s) begin bad++; $display("FAIL hit_stage[%0d] got=%h want=%h", i, bus.stage_reg, exp_s); end
      end
   endtask

   task automatic test_cold_miss;
      drive(32'h0000_1234, 4'hF);
      exp_q.push_back(model(32'h0000_1234, 4'hF));
      tick;
      held = exp_q.pop_front();
      total++; if (bus.stage_reg !== held || bus.stage_reg.tag !== 24'h9) begin bad++; $display("FAIL miss_capture got=%h want=%h", bus.stage_reg, held); end
      bus.halt = 1'b1;
      drive(32'h0000_2000, 4'hF);
      #1;
      total++; if (bus.arr_csb !== 1'b1) begin bad++; $display("FAIL halt_no_read got csb=%b want 1", bus.arr_csb); end
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         total++; if (bus.arr_csb !== 1'b1 || bus.stage_reg !== held) begin bad++; $display("FAIL miss_hold[%0d] got csb=%b stage=%h want 1/%h", k, bus.arr_csb, bus.stage_reg, held); end
         @(negedge clk);
      end
      bus.dfp_resp  = 1'b1;
      bus.lru_read  = 3'b000;
      bus.dfp_rdata = LINE_A;
      #1;
      total++; if (bus.arr_web !== 4'b1110 || bus.arr_csb !== 1'b0 || bus.arr_addr !== 4'd1) begin bad++; $display("FAIL fill_write got web=%b csb=%b addr=%0d want 1110/0/1", bus.arr_web, bus.arr_csb, bus.arr_addr); end
      total++; if (bus.tag_din !== 24'h000009 || bus.valid_din !== 1'b1 || bus.data_din !== LINE_A) begin bad++; $display("FAIL fill_din got tag=%h valid=%b want 000009/1", bus.tag_din, bus.valid_din); end
      @(negedge clk);
      bus.dfp_resp = 1'b0;
      #1;
      total++; if (bus.dfp_resp_reg !== 1'b1 || bus.arr_csb !== 1'b0 || bus.arr_addr !== 4'd1 || bus.arr_web !== 4'hF) begin bad++; $display("FAIL replay got resp=%b csb=%b addr=%0d web=%b want 1/0/1/1111", bus.dfp_resp_reg, bus.arr_csb, bus.arr_addr, bus.arr_web); end
      @(negedge clk);
      total++; if (rd_valid[0] !== 1'b1 || rd_tag[0] !== 24'h9 || rd_data[0] !== LINE_A || bus.dfp_resp_reg !== 1'b1) begin bad++; $display("FAIL wait_line got valid=%b tag=%h resp=%b want 1/000009/1", rd_valid[0], rd_tag[0], bus.dfp_resp_reg); end
      bus.halt = 1'b0;
      exp_q.push_back(model(32'h0000_2000, 4'hF));
      #1;
      total++; if (bus.arr_csb !== 1'b0 || bus.arr_addr !== 4'd0) begin bad++; $display("FAIL wait_capture_read got csb=%b addr=%0d want 0/0", bus.arr_csb, bus.arr_addr); end
      @(negedge clk);
      exp_s = exp_q.pop_front();
      total++; if (bus.stage_reg !== exp_s || bus.dfp_resp_reg !== 1'b0) begin bad++; $display("FAIL back_to_lookup got stage=%h resp=%b want %h/0", bus.stage_reg, bus.dfp_resp_reg, exp_s); end
      drive(32'h0, 4'h0);
   endtask

   task automatic test_victim_decode;
      logic [2:0]  lrus [3];
      logic [3:0]  webs [3];
      logic [31:0] a;
      lrus = '{3'b001, 3'b101, 3'b010};
      webs = '{4'b1011, 4'b0111, 4'b1101};
      for (int i = 0; i < 3; i++) begin
         a = 32'h0000_4000 | (32'(10 + i) << 5);
         drive(a, 4'hF);
         tick;
         bus.halt = 1'b1;
         drive(32'h0, 4'h0);
         tick;
         bus.dfp_resp  = 1'b1;
         bus.lru_read  = lrus[i];
         bus.dfp_rdata = LINE_C;
         #1;
         total++; if (bus.arr_web !== webs[i] || bus.arr_addr !== 4'(10 + i)) begin bad++; $display("FAIL victim[%b] got web=%b addr=%0d want %b/%0d", lrus[i], bus.arr_web, bus.arr_addr, webs[i], 10 + i); end
         @(negedge clk);
         bus.dfp_resp = 1'b0;
         @(negedge clk);
         bus.halt = 1'b0;
         tick;
      end
   endtask

   task automatic test_same_set_refill;
      drive(32'h0000_3434, 4'hF);
      exp_q.push_back(model(32'h0000_3434, 4'hF));
      tick;
      exp_s = exp_q.pop_front();
      total++; if (bus.stage_reg !== exp_s) begin bad++; $display("FAIL second_capture got=%h want=%h", bus.stage_reg, exp_s); end
      bus.halt = 1'b1;
      drive(32'h0, 4'h0);
      tick;
      bus.dfp_resp  = 1'b1;
      bus.lru_read  = 3'b001;
      bus.dfp_rdata = LINE_B;
      #1;
      total++; if (bus.arr_web !== 4'b1011 || bus.arr_addr !== 4'd1 || bus.tag_din !== 24'h1A) begin bad++; $display("FAIL second_victim got web=%b addr=%0d tag=%h want 1011/1/00001a", bus.arr_web, bus.arr_addr, bus.tag_din); end
      @(negedge clk);
      bus.dfp_resp = 1'b0;
      @(negedge clk);
      total++; if (rd_valid[2] !== 1'b1 || rd_tag[2] !== 24'h1A || rd_data[2] !== LINE_B) begin bad++; $display("FAIL second_line got valid=%b tag=%h want 1/00001a", rd_valid[2], rd_tag[2]); end
      total++; if (rd_valid[0] !== 1'b1 || rd_tag[0] !== 24'h9 || rd_data[0] !== LINE_A) begin bad++; $display("FAIL prior_line got valid=%b tag=%h want 1/000009", rd_valid[0], rd_tag[0]); end
      bus.halt = 1'b0;
      tick;
   endtask

   task automatic test_reset_in_replay;
      drive(32'h0001_2EE0, 4'hF);
      tick;
      bus.halt = 1'b1;
      drive(32'h0, 4'h0);
      tick;
      bus.dfp_resp  = 1'b1;
      bus.lru_read  = 3'b000;
      bus.dfp_rdata = LINE_C;
      @(negedge clk);
      bus.dfp_resp = 1'b0;
      rst = 1'b1;
      #1;
      total++; if (bus.dfp_resp_reg !== 1'b0 || bus.arr_csb !== 1'b1) begin bad++; $display("FAIL replay_reset got resp=%b csb=%b want 0/1", bus.dfp_resp_reg, bus.arr_csb); end
      @(negedge clk);
      rst = 1'b0;
      bus.halt = 1'b0;
      drive(32'h0001_2EE0, 4'hF);
      exp_q.push_back(model(32'h0001_2EE0, 4'hF));
      #1;
      total++; if (bus.arr_csb !== 1'b0 || bus.arr_addr !== 4'd7) begin bad++; $display("FAIL rerequest_read got csb=%b addr=%0d want 0/7", bus.arr_csb, bus.arr_addr); end
      @(negedge clk);
      exp_s = exp_q.pop_front();
      total++; if (bus.stage_reg !== exp_s || bus.dfp_resp_reg !== 1'b0) begin bad++; $display("FAIL rerequest_stage got=%h resp=%b want %h/0", bus.stage_reg, bus.dfp_resp_reg, exp_s); end
      total++; if (rd_valid[0] !== 1'b1 || rd_tag[0] !== 24'h97 || rd_data[0] !== LINE_C) begin bad++; $display("FAIL rerequest_hit got valid=%b tag=%h want 1/000097", rd_valid[0], rd_tag[0]); end
      drive(32'h0, 4'h0);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      for (int w = 0; w < 4; w++)
         for (int s = 0; s < 16; s++)
            mem_valid[w][s] = 1'b0;
      bus.ufp_addr  = '0;
      bus.ufp_rmask = '0;
      bus.halt      = 1'b0;
      bus.lru_read  = '0;
      bus.dfp_rdata = '0;
      bus.dfp_resp  = 1'b0;

      test_reset;
      test_pipelined_hits;
      test_cold_miss;
      test_victim_decode;
      test_same_set_refill;
      test_reset_in_replay;

      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
